// File: rtl/regfile_write_arbiter_if.sv
// Requester/regfile write-port bundle for regfile_write_arbiter.
// master = requester/regfile side, slave = arbiter side.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_dst;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_dst;
  logic [DATA_W-1:0]         wr_data;
  logic [GID_W-1:0]          grant_id;
  logic                      locked;

  modport master (
    output req_valid, req_lock, req_dst, req_data,
    input  req_ready, wr_en, wr_dst, wr_data,
    input  grant_id, locked
  );

  modport slave (
    input  req_valid, req_lock, req_dst, req_data,
    output req_ready, wr_en, wr_dst, wr_data,
    output grant_id, locked
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port.
// Define REGFILE_ARB_LOCK_EN to compile in burst locking with timeout.
module regfile_write_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 3,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [GID_W-1:0] f_wrap(
    input logic [GID_W-1:0] p,
    input int               k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return GID_W'(s);
  endfunction

  function automatic logic [GID_W-1:0] f_inc(
    input logic [GID_W-1:0] v
  );
    return f_wrap(v, 1);
  endfunction

  logic [GID_W-1:0]   r_ptr;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_dst;
  logic [DATA_W-1:0]  r_wr_data;
  logic [GID_W-1:0]   r_gid;

  logic               w_hit;
  logic [GID_W-1:0]   w_win;
  logic [NUM_REQ-1:0] w_ready;
  logic [ADDR_W-1:0]  w_dst;
  logic [DATA_W-1:0]  w_data;

`ifdef REGFILE_ARB_LOCK_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic {
    S_ARB,
    S_LOCKED
  } state_e;

  state_e             r_state;
  logic [GID_W-1:0]   r_owner;
  logic [TO_W-1:0]    r_cnt;
  logic               r_locked;
`else
  logic               w_unused;
  assign w_unused = ^{bus.req_lock, 32'(LOCK_TIMEOUT)};
`endif

  // First valid index at or after r_ptr; the lowest offset wins.
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[f_wrap(r_ptr, k)]) begin
        w_hit = 1'b1;
        w_win = f_wrap(r_ptr, k);
      end
    end
`ifdef REGFILE_ARB_LOCK_EN
    if (r_state == S_LOCKED) begin
      w_hit = bus.req_valid[r_owner];
      w_win = r_owner;
    end
`endif
  end

  always_comb begin
    w_ready = '0;
    if (w_hit) w_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_dst  = bus.req_dst[int'(w_win)*ADDR_W +: ADDR_W];
    w_data = bus.req_data[int'(w_win)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_dst  <= '0;
      r_wr_data <= '0;
      r_gid     <= '0;
`ifdef REGFILE_ARB_LOCK_EN
      r_state   <= S_ARB;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_locked  <= 1'b0;
`endif
    end else begin
      r_wr_en <= w_hit;
      if (w_hit) begin
        r_wr_dst  <= w_dst;
        r_wr_data <= w_data;
        r_gid     <= w_win;
      end
`ifdef REGFILE_ARB_LOCK_EN
      unique case (r_state)
        S_ARB: begin
          if (w_hit) begin
            r_ptr <= f_inc(w_win);
            if (bus.req_lock[w_win]) begin
              r_state  <= S_LOCKED;
              r_owner  <= w_win;
              r_cnt    <= '0;
              r_locked <= 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (w_hit) begin
            r_cnt <= '0;
            if (!bus.req_lock[w_win]) begin
              r_state  <= S_ARB;
              r_locked <= 1'b0;
              r_ptr    <= f_inc(r_owner);
            end
          end else if (r_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
            // Owner went quiet too long: hand the port back.
            r_state  <= S_ARB;
            r_locked <= 1'b0;
            r_cnt    <= '0;
            r_ptr    <= f_inc(r_owner);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
`else
      if (w_hit) r_ptr <= f_inc(w_win);
`endif
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_dst    = r_wr_dst;
  assign bus.wr_data   = r_wr_data;
  assign bus.grant_id  = r_gid;
`ifdef REGFILE_ARB_LOCK_EN
  assign bus.locked    = r_locked;
`else
  assign bus.locked    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based scoreboard fed by a
// request-level reference model, directed scenarios plus random traffic.
module tb_regfile_write_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int TO = 15;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(
    .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)
  ) bus ();

  regfile_write_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .LOCK_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic          en;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
    logic [GW-1:0] gid;
    logic          lk;
  } beat_t;

  beat_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0]  pv;
  logic [N-1:0]  pl;
  logic [AW-1:0] pd[N];
  logic [DW-1:0] pdat[N];

  int            m_ptr;
  int            m_owner;
  int            m_cnt;
  bit            m_lk;
  logic [AW-1:0] m_dst;
  logic [DW-1:0] m_data;
  int            m_gid;
  int            m_last_win;

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_lk = 0;
    m_dst = '0; m_data = '0; m_gid = 0; m_last_win = -1;
    pv = '0; pl = '0;
    sb.delete();
  endtask

  task automatic drive();
    bus.req_valid = pv;
    bus.req_lock  = pl;
    for (int i = 0; i < N; i++) begin
      bus.req_dst[i*AW +: AW]  = pd[i];
      bus.req_data[i*DW +: DW] = pdat[i];
    end
  endtask

  // Reference: decide this cycle's winner from pending requests,
  // check ready, and queue the beat the write port must show next.
  task automatic step();
    logic [N-1:0] er;
    int           win;
    bit           wl;
    beat_t        b;
    er  = '0;
    win = -1;
    wl  = 0;
    if (m_lk) begin
      if (pv[m_owner]) win = m_owner;
    end else begin
      for (int k = 0; k < N; k++)
        if (win < 0 && pv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    if (win >= 0) er[win] = 1'b1;
    vectors++;
    if (bus.req_ready !== er) begin
      miscompares++;
      $display("FAIL ready: got %b want %b", bus.req_ready, er);
    end
    m_last_win = win;
    if (win >= 0) begin
      m_dst  = pd[win];
      m_data = pdat[win];
      m_gid  = win;
      wl     = pl[win];
      pv[win] = 1'b0;
    end
`ifdef REGFILE_ARB_LOCK_EN
    if (m_lk) begin
      if (win >= 0) begin
        m_cnt = 0;
        if (!wl) begin m_lk = 0; m_ptr = (m_owner + 1) % N; end
      end else begin
        m_cnt++;
        if (m_cnt == TO) begin
          m_lk = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
        end
      end
    end else if (win >= 0) begin
      m_ptr = (win + 1) % N;
      if (wl) begin m_lk = 1; m_owner = win; m_cnt = 0; end
    end
`else
    if (win >= 0) m_ptr = (win + 1) % N;
`endif
    b.en   = (win >= 0);
    b.dst  = m_dst;
    b.data = m_data;
    b.gid  = GW'(m_gid);
    b.lk   = m_lk;
    sb.push_back(b);
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    step();
  endtask

  task automatic wait_accept(input int i, input int max);
    int n;
    n = 0;
    while (pv[i] && n < max) begin cycle(); n++; end
    vectors++;
    if (pv[i]) begin
      miscompares++;
      $display("FAIL accept_timeout: req%0d still pending after %0d", i, n);
    end
  endtask

  task automatic rand_cycles(input int n);
    repeat (n) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i]) begin
          if ($urandom_range(2) == 0) begin
            pv[i]   = 1'b1;
            pd[i]   = AW'($urandom);
            pdat[i] = DW'($urandom);
            pl[i]   = ($urandom_range(3) == 0);
          end
        end else if ($urandom_range(15) == 0) begin
          pv[i] = 1'b0;
        end
      end
      cycle();
    end
  endtask

  // Monitor: every clock with reset released consumes one expected beat.
  initial begin
    beat_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (sb.size() == 0) begin
          vectors++;
          if (bus.wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_write: got wr_en=%b want 0", bus.wr_en);
          end
        end else begin
          e = sb.pop_front();
          vectors++;
          if (bus.wr_en !== e.en || bus.wr_dst !== e.dst ||
              bus.wr_data !== e.data || bus.grant_id !== e.gid ||
              bus.locked !== e.lk) begin
            miscompares++;
            $display("FAIL beat: got en=%b dst=%0d data=%h gid=%0d lk=%b want en=%b dst=%0d data=%h gid=%0d lk=%b",
                     bus.wr_en, bus.wr_dst, bus.wr_data, bus.grant_id,
                     bus.locked, e.en, e.dst, e.data, e.gid, e.lk);
          end
        end
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin pd[i] = '0; pdat[i] = '0; end
    model_reset();
    drive();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.wr_dst !== '0 || bus.wr_data !== '0 ||
        bus.grant_id !== '0 || bus.locked !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: en=%b dst=%0d data=%h gid=%0d lk=%b want all 0",
               bus.wr_en, bus.wr_dst, bus.wr_data, bus.grant_id, bus.locked);
    end

    repeat (5) cycle();

    // All three valid: rotation 0,1,2,0,1,2.
    repeat (6) begin
      for (int i = 0; i < N; i++) begin
        pv[i] = 1'b1; pl[i] = 1'b0;
        pd[i] = AW'(i); pdat[i] = DW'(8'h10 * (i + 1));
      end
      cycle();
    end
    pv = '0;

    // Lone requester 1.
    pv[1] = 1'b1; pl[1] = 1'b0; pd[1] = 3'd5; pdat[1] = 8'hA5;
    cycle();
    vectors++;
    if (m_last_win != 1) begin
      miscompares++;
      $display("FAIL lone_req1: winner %0d want 1", m_last_win);
    end
    repeat (2) cycle();

`ifdef REGFILE_ARB_LOCK_EN
    // Burst from req2 while req0 waits.
    pv[0] = 1'b1; pl[0] = 1'b0; pd[0] = 3'd1; pdat[0] = 8'h55;
    for (int b = 0; b < 3; b++) begin
      pv[2] = 1'b1; pl[2] = (b < 2); pd[2] = AW'(b); pdat[2] = DW'(8'hC0 + b);
      wait_accept(2, 20);
    end
    vectors++;
    if (!pv[0]) begin
      miscompares++;
      $display("FAIL lock_hold: req0 granted during burst, want still pending");
    end
    wait_accept(0, 5);

    // Lock then go idle: release after TO idle cycles.
    pv[0] = 1'b1; pl[0] = 1'b1; pd[0] = 3'd7; pdat[0] = 8'hEE;
    wait_accept(0, 5);
    pv[1] = 1'b1; pl[1] = 1'b0; pd[1] = 3'd0; pdat[1] = 8'h3C;
    n = 0;
    while (pv[1] && n < 30) begin cycle(); n++; end
    vectors++;
    if (n != TO + 1) begin
      miscompares++;
      $display("FAIL lock_timeout: req1 accepted after %0d cycles want %0d", n, TO + 1);
    end
`else
    // Lock requests are ignored: req0/req1 alternate.
    repeat (6) begin
      pv[0] = 1'b1; pl[0] = 1'b1; pd[0] = 3'd2; pdat[0] = 8'h01;
      pv[1] = 1'b1; pl[1] = 1'b0; pd[1] = 3'd3; pdat[1] = 8'h02;
      n = m_last_win;
      cycle();
      vectors++;
      if (n >= 0 && m_last_win == n) begin
        miscompares++;
        $display("FAIL no_lock_alt: winner %0d repeated", m_last_win);
      end
    end
    pv = '0;
`endif

    rand_cycles(400);

    // Reset in the middle of traffic.
    pv = '0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b1; pl[i] = (i == 0); pd[i] = AW'(i + 4);
      pdat[i] = DW'(8'h70 + i);
    end
    cycle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.wr_en !== 1'b0 || bus.locked !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: wr_en=%b locked=%b want 0 0", bus.wr_en, bus.locked);
    end
    model_reset();
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    rand_cycles(60);
    pv = '0;
    repeat (TO + 3) cycle();
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d beats left want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
